id_ex_stage: RTL

ID/EX pipeline stage for the 5-stage RV32 pipelined CPU. It latches the Control unit's decoded signals and the ID-stage operands into the EX stage, and detects load-use hazards. On a hazard it drives NoOp_o back into Control and freezes PC and IF/ID. It also honours branch flushes and data-memory stalls, inserting bubbles and holding state as required.

---
 rtl/id_ex_pkg.sv | 37 +++
 rtl/load_use_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pkg
// Description : Shared types and constants for the ID/EX pipeline stage:
//               decoded control bundle, bubble constant, RV32 opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pkg;

   // Control bundle produced by the Control unit and carried into EX
   typedef struct packed {
      logic       RegWrite;
      logic       MemtoReg;
      logic       MemRead;
      logic       MemWrite;
      logic [1:0] ALUOp;
      logic       ALUSrc;
      logic       Branch;
   } ctrl_t;

   // A bubble carries no side effects: every control bit cleared
   localparam ctrl_t CTRL_BUBBLE = '0;

   // RV32I major opcodes decoded by Control
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // True when the bundle describes a load (the only producer that can stall)
   function automatic logic is_load(input ctrl_t c);
      return c.MemRead;
   endfunction

endpackage : id_ex_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in ID reads the destination of a load in EX.
//               Loads to x0 never create a dependency.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
   import id_ex_pkg::*;
(
   input  logic       ex_valid_i,
   input  ctrl_t      ex_ctrl_i,
   input  logic [4:0] ex_rd_addr_i,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   output logic       lu_o
);

   logic ex_load;
   logic rd_nonzero;
   logic src_match;

   // Hazard = valid load in EX with a nonzero rd that a valid ID source reads
   always_comb begin
      ex_load    = ex_valid_i & is_load(ex_ctrl_i);
      rd_nonzero = (ex_rd_addr_i != 5'd0);
      src_match  = (ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i);
      lu_o       = ex_load & rd_nonzero & id_valid_i & src_match;
   end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use hazard detection.
//               Captures Control outputs and ID operands, inserts bubbles on
//               branch flush or load-use, and freezes on data-memory stall.
//               Optional macro ID_EX_PERF_CNT_EN builds a saturating
//               inserted-bubble counter on bubble_cnt_o (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // Control unit outputs
   input  logic            RegWrite_i,
   input  logic            MemtoReg_i,
   input  logic            MemRead_i,
   input  logic            MemWrite_i,
   input  logic            ALUSrc_i,
   input  logic            Branch_i,
   input  logic [1:0]      ALUOp_i,
   // ID-stage instruction fields and operands
   input  logic            valid_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   input  logic [4:0]      rd_addr_i,
   input  logic [9:0]      funct_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   // Pipeline control
   input  logic            flush_i,
   input  logic            mem_stall_i,
   // Registered control to EX
   output logic            RegWrite_o,
   output logic            MemtoReg_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic            ALUSrc_o,
   output logic            Branch_o,
   output logic [1:0]      ALUOp_o,
   // Registered instruction fields and operands
   output logic            valid_o,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   output logic [4:0]      rd_addr_o,
   output logic [9:0]      funct_o,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic [XLEN-1:0] imm_o,
   // Hazard feedback
   output logic            NoOp_o,
   output logic            PCWrite_o,
   output logic            IFIDWrite_o,
   output logic [31:0]     bubble_cnt_o
);

   ctrl_t            ctrl_in;
   ctrl_t            ctrl_d,     ctrl_q;
   logic             valid_d,    valid_q;
   logic [4:0]       rs1_addr_d, rs1_addr_q;
   logic [4:0]       rs2_addr_d, rs2_addr_q;
   logic [4:0]       rd_addr_d,  rd_addr_q;
   logic [9:0]       funct_d,    funct_q;
   logic [XLEN-1:0]  rs1_data_d, rs1_data_q;
   logic [XLEN-1:0]  rs2_data_d, rs2_data_q;
   logic [XLEN-1:0]  imm_d,      imm_q;
   logic             lu;

   // Pack the loose Control outputs into the shared bundle
   always_comb begin
      ctrl_in          = CTRL_BUBBLE;
      ctrl_in.RegWrite = RegWrite_i;
      ctrl_in.MemtoReg = MemtoReg_i;
      ctrl_in.MemRead  = MemRead_i;
      ctrl_in.MemWrite = MemWrite_i;
      ctrl_in.ALUOp    = ALUOp_i;
      ctrl_in.ALUSrc   = ALUSrc_i;
      ctrl_in.Branch   = Branch_i;
   end

   load_use_detect u_load_use_detect (
      .ex_valid_i    (valid_q),
      .ex_ctrl_i     (ctrl_q),
      .ex_rd_addr_i  (rd_addr_q),
      .id_valid_i    (valid_i),
      .id_rs1_addr_i (rs1_addr_i),
      .id_rs2_addr_i (rs2_addr_i),
      .lu_o          (lu)
   );

   // Hazard feedback is purely combinational so the freeze lands this cycle
   always_comb begin
      NoOp_o      = lu;
      PCWrite_o   = ~lu & ~mem_stall_i;
      IFIDWrite_o = ~lu & ~mem_stall_i;
   end

   // Next state: stall holds, flush or load-use loads a zeroed bubble, else capture
   always_comb begin
      ctrl_d     = ctrl_q;
      valid_d    = valid_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_addr_d  = rd_addr_q;
      funct_d    = funct_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      if (!mem_stall_i) begin
         if (flush_i || lu) begin
            // Data fields are don't-care in a bubble; zero keeps traces deterministic
            ctrl_d     = CTRL_BUBBLE;
            valid_d    = 1'b0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            funct_d    = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
         end else begin
            ctrl_d     = ctrl_in;
            valid_d    = valid_i;
            rs1_addr_d = rs1_addr_i;
            rs2_addr_d = rs2_addr_i;
            rd_addr_d  = rd_addr_i;
            funct_d    = funct_i;
            rs1_data_d = rs1_data_i;
            rs2_data_d = rs2_data_i;
            imm_d      = imm_i;
         end
      end
   end

   // Pipeline register, cleared asynchronously to an empty (invalid) stage
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q     <= CTRL_BUBBLE;
         valid_q    <= 1'b0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         funct_q    <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         funct_q    <= funct_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic        bubble_take;
   logic [31:0] bubble_cnt_d, bubble_cnt_q;

   // A bubble is counted once per edge it is captured; flush+lu together is one
   always_comb begin
      bubble_take  = ~mem_stall_i & (flush_i | lu);
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_take && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   // Saturating bubble counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`else
   assign bubble_cnt_o = 32'd0;
`endif

   // Drive registered outputs from the pipeline register
   always_comb begin
      RegWrite_o = ctrl_q.RegWrite;
      MemtoReg_o = ctrl_q.MemtoReg;
      MemRead_o  = ctrl_q.MemRead;
      MemWrite_o = ctrl_q.MemWrite;
      ALUOp_o    = ctrl_q.ALUOp;
      ALUSrc_o   = ctrl_q.ALUSrc;
      Branch_o   = ctrl_q.Branch;
      valid_o    = valid_q;
      rs1_addr_o = rs1_addr_q;
      rs2_addr_o = rs2_addr_q;
      rd_addr_o  = rd_addr_q;
      funct_o    = funct_q;
      rs1_data_o = rs1_data_q;
      rs2_data_o = rs2_data_q;
      imm_o      = imm_q;
   end

endmodule : id_ex_stage
`default_nettype wire
